// File: rtl/jt49_env_pkg.sv
// Shared constants and types for the JT49 envelope generator.
// Covers shape register bit positions, FSM encoding, step maxima and the AY level map.
package jt49_env_pkg;

    localparam int SH_CONT = 3;
    localparam int SH_ATT  = 2;
    localparam int SH_ALT  = 1;
    localparam int SH_HOLD = 0;

    localparam logic [4:0] STEP_MAX_AY = 5'd15;
    localparam logic [4:0] STEP_MAX_YM = 5'd31;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } env_state_e;

    // Stretch a 4-bit AY level to 5 bits so that 0 stays 0 and 15 becomes 31.
    function automatic logic [4:0] ay_level(input logic [3:0] lvl4);
        return {lvl4, lvl4[3]};
    endfunction

endpackage

// File: rtl/jt49_env_cnt.sv
// Envelope period counter: one strobe every max(period,1) enables.
// The strobe is combinational so the parent can step on the same falling edge.
module jt49_env_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        clr,
    input  logic [15:0] period,
    output logic        strobe
);

    logic [15:0] pcnt;
    logic [16:0] next_cnt;
    logic [16:0] limit;

    // A 17-bit compare keeps pcnt=FFFF from wrapping; a count already past a
    // freshly lowered limit strobes on the next enable.
    assign limit    = (period == 16'd0) ? 17'd1 : {1'b0, period};
    assign next_cnt = {1'b0, pcnt} + 17'd1;
    assign strobe   = cen & ~clr & (next_cnt >= limit);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= 16'd0;
        end else if (clr) begin
            pcnt <= 16'd0;
        end else if (cen) begin
            pcnt <= strobe ? 16'd0 : next_cnt[15:0];
        end
    end

endmodule

// File: rtl/jt49_env.sv
// JT49 envelope generator: steps a 16 (AY) or 32 (YM) level envelope through
// the AY/YM shapes, clocked on the falling edge by the cen256 enable.
module jt49_env
    import jt49_env_pkg::*;
#(
    parameter bit YM = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic [15:0] period,
    input  logic [3:0]  shape,
    input  logic        restart,
    output logic [4:0]  env,
    output logic        busy
);

    localparam logic [4:0] STEP_MAX = YM ? STEP_MAX_YM : STEP_MAX_AY;

    env_state_e state, state_nx;
    logic [4:0] step, step_nx, step_inc;
    logic       inv, inv_nx;
    logic [4:0] env_nx;
    logic       strobe;

    function automatic logic [4:0] out_level(input logic [4:0] stp, input logic iv);
        logic [4:0] lvl;
        lvl = stp ^ {5{iv}};
        return YM ? lvl : ay_level(lvl[3:0]);
    endfunction

    // The counter only sees enables while running, so pcnt freezes in HOLD.
    jt49_env_cnt u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen & (state == ST_RUN)),
        .clr    (restart),
        .period (period),
        .strobe (strobe)
    );

    assign step_inc = step + 5'd1;
    assign busy     = (state == ST_RUN);

    always_comb begin
        state_nx = state;
        step_nx  = step;
        inv_nx   = inv;
        env_nx   = env;
        if (restart) begin
            state_nx = ST_RUN;
            step_nx  = 5'd0;
            inv_nx   = ~shape[SH_ATT];
            env_nx   = out_level(5'd0, ~shape[SH_ATT]);
        end else if (state == ST_RUN && strobe) begin
            if (step == STEP_MAX) begin
                if (!shape[SH_CONT]) begin
                    state_nx = ST_HOLD;
                    env_nx   = 5'd0;
                end else if (shape[SH_HOLD]) begin
                    state_nx = ST_HOLD;
                    env_nx   = (shape[SH_ATT] ^ shape[SH_ALT]) ? 5'd31 : 5'd0;
                end else begin
                    step_nx = 5'd0;
                    inv_nx  = inv ^ shape[SH_ALT];
                    env_nx  = out_level(5'd0, inv ^ shape[SH_ALT]);
                end
            end else begin
                step_nx = step_inc;
                env_nx  = out_level(step_inc, inv);
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HOLD;
            step  <= 5'd0;
            inv   <= 1'b1;
            env   <= 5'd0;
        end else begin
            state <= state_nx;
            step  <= step_nx;
            inv   <= inv_nx;
            env   <= env_nx;
        end
    end

endmodule

// File: tb/tb_jt49_env.sv
// Directed bench for jt49_env: one YM-mode and one AY-mode instance share the
// stimulus; inputs change and outputs are sampled on the rising edge.
module tb_jt49_env;

    logic        clk;
    logic        rst_n;
    logic        cen;
    logic [15:0] period;
    logic [3:0]  shape;
    logic        restart;
    logic [4:0]  env_ym, env_ay;
    logic        busy_ym, busy_ay;

    int n_checks;
    int n_errors;

    jt49_env #(.YM(1'b1)) dut_ym (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen),
        .period  (period),
        .shape   (shape),
        .restart (restart),
        .env     (env_ym),
        .busy    (busy_ym)
    );

    jt49_env #(.YM(1'b0)) dut_ay (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen),
        .period  (period),
        .shape   (shape),
        .restart (restart),
        .env     (env_ay),
        .busy    (busy_ay)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // driver tasks: called at a rising edge, return at the next rising edge
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    task automatic pulse_cen();
        cen = 1'b1;
        @(posedge clk);
        cen = 1'b0;
    endtask

    task automatic pulse_cens(input int n);
        for (int i = 0; i < n; i++) pulse_cen();
    endtask

    task automatic do_restart(input logic with_cen);
        restart = 1'b1;
        cen     = with_cen;
        @(posedge clk);
        restart = 1'b0;
        cen     = 1'b0;
    endtask

    function automatic logic [4:0] ay_exp(input int v);
        return 5'((2 * v) + ((v >= 8) ? 1 : 0));
    endfunction

    int exp_lvl;
    int stp;
    int iv;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        cen      = 1'b0;
        period   = 16'd1;
        shape    = 4'b0000;
        restart  = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // reset state, then enables without restart leave it idle
        check("reset_env_ym", 32'(env_ym), 0);
        check("reset_busy_ym", 32'(busy_ym), 0);
        check("reset_env_ay", 32'(env_ay), 0);
        check("reset_busy_ay", 32'(busy_ay), 0);
        for (int i = 0; i < 100; i++) begin
            pulse_cen();
            check("idle_env", 32'(env_ym), 0);
            check("idle_busy", 32'(busy_ym), 0);
        end

        // YM attack with hold, period 2
        shape  = 4'b1101;
        period = 16'd2;
        do_restart(1'b0);
        check("att_start_env", 32'(env_ym), 0);
        check("att_start_busy", 32'(busy_ym), 1);
        for (int k = 1; k <= 31; k++) begin
            pulse_cen();
            check("att_mid", 32'(env_ym), 32'(k - 1));
            pulse_cen();
            check("att_step", 32'(env_ym), 32'(k));
        end
        pulse_cens(2);
        check("att_hold_env", 32'(env_ym), 31);
        check("att_hold_busy", 32'(busy_ym), 0);
        pulse_cens(6);
        check("att_hold_stay", 32'(env_ym), 31);

        // AY sawtooth decay, period 1, two full cycles
        shape  = 4'b1000;
        period = 16'd1;
        do_restart(1'b0);
        check("saw_start", 32'(env_ay), 31);
        for (int s = 1; s <= 32; s++) begin
            pulse_cen();
            check("saw_step", 32'(env_ay), 32'(ay_exp(15 - (s % 16))));
        end
        check("saw_busy", 32'(busy_ay), 1);

        // YM triangle, period 1
        shape = 4'b1110;
        do_restart(1'b0);
        check("tri_start", 32'(env_ym), 0);
        for (int i = 1; i <= 96; i++) begin
            pulse_cen();
            stp     = i % 32;
            iv      = (i / 32) % 2;
            exp_lvl = (iv != 0) ? (31 - stp) : stp;
            check("tri_step", 32'(env_ym), 32'(exp_lvl));
        end

        // YM decay with alternate+hold, period 3
        shape  = 4'b1011;
        period = 16'd3;
        do_restart(1'b0);
        check("dah_start", 32'(env_ym), 31);
        for (int s = 1; s <= 31; s++) begin
            pulse_cens(2);
            check("dah_mid", 32'(env_ym), 32'(31 - (s - 1)));
            pulse_cen();
            check("dah_step", 32'(env_ym), 32'(31 - s));
        end
        pulse_cens(3);
        check("dah_hold_env", 32'(env_ym), 31);
        check("dah_hold_busy", 32'(busy_ym), 0);

        // restart coinciding with cen mid-cycle
        shape  = 4'b1100;
        period = 16'd4;
        do_restart(1'b0);
        pulse_cens(6);
        check("rc_before", 32'(env_ym), 1);
        do_restart(1'b1);
        check("rc_env", 32'(env_ym), 0);
        check("rc_busy", 32'(busy_ym), 1);
        pulse_cens(3);
        check("rc_wait", 32'(env_ym), 0);
        pulse_cen();
        check("rc_step", 32'(env_ym), 1);

        // lowering the period below the current count strobes on the next cen
        period = 16'd8;
        do_restart(1'b0);
        pulse_cens(5);
        check("pchg_before", 32'(env_ym), 0);
        period = 16'd2;
        pulse_cen();
        check("pchg_strobe", 32'(env_ym), 1);
        pulse_cen();
        check("pchg_next", 32'(env_ym), 1);
        pulse_cen();
        check("pchg_after", 32'(env_ym), 2);

        // period 0 acts as period 1
        period = 16'd0;
        do_restart(1'b0);
        for (int i = 1; i <= 5; i++) begin
            pulse_cen();
            check("p0_step", 32'(env_ym), 32'(i));
        end

        // asynchronous reset mid-cycle, then idle until restart
        rst_n = 1'b0;
        #1;
        check("arst_env", 32'(env_ym), 0);
        check("arst_busy", 32'(busy_ym), 0);
        @(posedge clk);
        rst_n = 1'b1;
        idle(1);
        pulse_cens(4);
        check("arst_idle_env", 32'(env_ym), 0);
        check("arst_idle_busy", 32'(busy_ym), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
